// File: rtl/stream_tg_pkg.sv
// Shared types and LFSR helpers for the stream traffic generator.
// The LFSR is a 32-bit right-shifting Galois form, x^32+x^22+x^2+x+1.
package stream_tg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam int unsigned BEAT_W    = 12;
  localparam int unsigned GAP_W     = 8;

  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit payload LFSR with seed load and per-step enable.
import stream_tg_pkg::*;

module lfsr32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] seed,
  output logic [31:0] value
);

  always_ff @(posedge clk) begin
    if (!rst_n || load) begin
      value <= seed;
    end else if (en) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/stream_traffic_gen.sv
// Packetised streaming traffic generator: runs of num_pkts packets of LFSR payload,
// round-robin stream IDs, optional inter-packet gap and graceful stop.
import stream_tg_pkg::*;

module stream_traffic_gen #(
  parameter int unsigned DATA_WIDTH    = 512,
  parameter int unsigned N_STREAMS     = 4,
  parameter int unsigned BEATS_PER_PKT = 4,
  parameter int unsigned GAP_CYCLES    = 0,
  parameter logic [31:0] LFSR_SEED     = 32'hACE1_0001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [15:0]           num_pkts,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [3:0]            sid_out,
  output logic                  data_valid,
  output logic                  data_last,
  input  logic                  data_ready,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           pkt_count
);

  localparam int unsigned       LANES     = DATA_WIDTH / 32;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_PKT - 1);
  localparam logic [3:0]        LAST_SID  = 4'(N_STREAMS - 1);
  localparam logic [GAP_W-1:0]  LAST_GAP  = GAP_W'(GAP_CYCLES - 1);

  state_t            state;
  state_t            state_next;
  logic [BEAT_W-1:0] beat_cnt;
  logic [BEAT_W-1:0] beat_nxt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [15:0]       pkts_lat;
  logic              stop_lat;
  logic [31:0]       lfsr_q;
  logic              valid_d;
  logic              last_d;
  logic              busy_d;
  logic              done_d;
  logic              xfer;
  logic              last_xfer;
  logic              start_acc;
  logic              stop_seen;
  logic              run_end;

  assign xfer      = data_valid & data_ready;
  assign last_xfer = xfer & data_last;
  assign start_acc = (state == ST_IDLE) & start;
  assign stop_seen = stop_lat | stop;
  assign run_end   = ((pkt_count + 16'd1) == pkts_lat) | stop_seen;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) state_next = (num_pkts == 16'd0) ? ST_DONE : ST_SEND;
      end
      ST_SEND: begin
        if (last_xfer) begin
          if (run_end)              state_next = ST_DONE;
          else if (GAP_CYCLES != 0) state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt == LAST_GAP) state_next = stop_seen ? ST_DONE : ST_SEND;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Next-cycle values of the registered outputs, derived from the next state.
  always_comb begin
    beat_nxt = beat_cnt;
    valid_d  = (state_next == ST_SEND);
    busy_d   = (state_next == ST_SEND) || (state_next == ST_GAP);
    done_d   = (state_next == ST_DONE);
    if (start_acc) begin
      beat_nxt = '0;
    end else if (xfer) begin
      beat_nxt = data_last ? '0 : beat_cnt + BEAT_W'(1);
    end
    last_d = valid_d && (beat_nxt == LAST_BEAT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_valid <= 1'b0;
      data_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sid_out    <= '0;
      pkt_count  <= '0;
      beat_cnt   <= '0;
      gap_cnt    <= '0;
      pkts_lat   <= '0;
      stop_lat   <= 1'b0;
    end else begin
      data_valid <= valid_d;
      data_last  <= last_d;
      busy       <= busy_d;
      done       <= done_d;
      beat_cnt   <= beat_nxt;
      gap_cnt    <= (state == ST_GAP) ? gap_cnt + GAP_W'(1) : '0;
      if (start_acc) begin
        pkts_lat  <= num_pkts;
        pkt_count <= '0;
        sid_out   <= '0;
        stop_lat  <= 1'b0;
      end else if (last_xfer) begin
        pkt_count <= pkt_count + 16'd1;
        sid_out   <= (sid_out == LAST_SID) ? '0 : sid_out + 4'd1;
      end
      if (((state == ST_SEND) || (state == ST_GAP)) && stop) stop_lat <= 1'b1;
    end
  end

  lfsr32 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (xfer),
    .load  (1'b0),
    .seed  (LFSR_SEED),
    .value (lfsr_q)
  );

  // Each 32-bit lane carries the LFSR value tagged with its lane index.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign data_out[32*k +: 32] = lfsr_q ^ 32'(k);
  end

endmodule

// File: doc/stream_traffic_gen.md
STREAM_TRAFFIC_GEN -- requirements
Module: stream_traffic_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512: payload width in bits; a multiple of 32.
REQ-002 SHALL have parameter N_STREAMS, default 4: number of stream IDs cycled; 1..16.
REQ-003 SHALL have parameter BEATS_PER_PKT, default 4: beats per packet; 1..4095.
REQ-004 SHALL have parameter GAP_CYCLES, default 0: idle cycles inserted between packets; 0..255.
REQ-005 SHALL have parameter LFSR_SEED, default 32'hACE1_0001: non-zero LFSR start value.
REQ-006 SHALL have port clk, input, 1: the single clock; one clock, all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-008 SHALL have port start, input, 1: single-cycle run request.
REQ-009 SHALL have port stop, input, 1: graceful abort request.
REQ-010 SHALL have port num_pkts, input, 16: packets per run, sampled on accepted start.
REQ-011 SHALL have port data_out, output, DATA_WIDTH: beat payload.
REQ-012 SHALL have port sid_out, output, 4: stream ID of the current packet.
REQ-013 SHALL have port data_valid, output, 1: beat valid.
REQ-014 SHALL have port data_last, output, 1: final beat of a packet.
REQ-015 SHALL have port data_ready, input, 1: sink acceptance.
REQ-016 SHALL have port busy, output, 1: high in SEND and GAP.
REQ-017 SHALL have port done, output, 1: one-cycle end-of-run pulse.
REQ-018 SHALL have port pkt_count, output, 16: packets completed in the current or last run.

Function
REQ-019 SHALL implement FSM states IDLE, SEND, GAP, DONE.
REQ-020 A beat SHALL transfer only on a cycle with data_valid=1 and data_ready=1.
REQ-021 Once asserted, data_valid, data_out, sid_out and data_last SHALL hold stable until the beat transfers.
REQ-022 IDLE: start=1 SHALL latch num_pkts, clear pkt_count, and move to SEND, or to DONE when num_pkts=0.
REQ-023 data_valid SHALL be 1 exactly when state is SEND, so the first beat appears one cycle after start.
REQ-024 A beat counter SHALL run 0..BEATS_PER_PKT-1; data_last=1 when it equals BEATS_PER_PKT-1.
REQ-025 On transfer of a last beat, pkt_count SHALL increment.
REQ-026 On transfer of a last beat, sid_out SHALL advance modulo N_STREAMS, starting at 0 for each run.
REQ-027 After a last-beat transfer, next state SHALL be DONE when pkt_count+1 equals the latched num_pkts or stop has been seen, else GAP.
REQ-028 With GAP_CYCLES=0, GAP SHALL be skipped and the next packet SHALL transfer on the very next cycle.
REQ-029 GAP SHALL hold data_valid=0 for exactly GAP_CYCLES cycles, then return to SEND.
REQ-030 stop=1 in SEND or GAP SHALL be latched; the current packet SHALL complete, and a stop seen in GAP SHALL go to DONE at gap end.
REQ-031 stop SHALL be ignored in IDLE and DONE, and start SHALL be ignored outside IDLE.
REQ-032 DONE SHALL assert done for one cycle, then go to IDLE; pkt_count SHALL hold until the next accepted start.
REQ-033 Payload: a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1, right-shift, tap mask 32'h8020_0003.
REQ-034 The LFSR SHALL advance once per transferred beat and SHALL persist across runs.
REQ-035 32-bit lane k of data_out SHALL equal lfsr XOR k, for k = 0..DATA_WIDTH/32-1.
REQ-036 pkt_count SHALL wrap from 16'hFFFF to 0 with no flag.

Reset
REQ-037 On rst_n=0 at a clock edge: state=IDLE, data_valid=0, data_last=0, done=0, busy=0, sid_out=0, pkt_count=0, beat counter=0, stop latch=0, lfsr=LFSR_SEED, data_out = lanes of LFSR_SEED XOR k.
REQ-038 Reset mid-packet SHALL abort immediately; no partial-packet completion.

Structure
REQ-039 Package stream_tg_pkg SHALL hold the state enum, the LFSR tap constant, and the LFSR next-value function.
REQ-040 Sub-module lfsr32 (enable, seed load) SHALL be instantiated once.

Verification
REQ-041 Reset, then start with num_pkts=3, ready=1 -> 12 contiguous beats; sid sequence 0,0,0,0,1,...,2; last on beats 4/8/12; done one cycle after beat 12; pkt_count=3.
REQ-042 Lane check -> beat 0 lane 0 = 32'hACE1_0001, lane 1 = 32'hACE1_0000; beat 1 lane 0 = the LFSR next value of the seed.
REQ-043 GAP_CYCLES=2, num_pkts=2 -> exactly 2 valid-low cycles between the two packets.
REQ-044 ready toggling 1,0,0,1 during SEND -> data/sid/last stable while stalled; no beat lost or duplicated; 8 transfers total for num_pkts=2.
REQ-045 stop on the 2nd beat of packet 1 with num_pkts=10 -> packet 1 completes, done, pkt_count=2; start while busy ignored.
REQ-046 num_pkts=0 -> no valid; done one cycle after start. rst_n=0 mid-packet -> valid drops next edge and all outputs return to reset values.
